// File: rtl/rv32im_multicycle_core.sv
// Multicycle RV32IM core: internal instruction/data memories, iterative
// multiply/divide unit, ECALL halt and retired-instruction counter.
module rv32im_multicycle_core #(
    parameter int WIDTH      = 32,
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_BYTES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             insMemEn,
    input  logic [WIDTH-1:0] insMemAddr,
    input  logic [WIDTH-1:0] insMemData,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] gp,
    output logic [WIDTH-1:0] a7,
    output logic             halted,
    output logic [WIDTH-1:0] instret
);
    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_BYTES);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] EXEC   = 3'd1;
    localparam logic [2:0] MEM    = 3'd2;
    localparam logic [2:0] MULDIV = 3'd3;
    localparam logic [2:0] HALT   = 3'd4;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    logic [31:0] imem [IMEM_WORDS];
    logic [7:0]  dmem [DMEM_BYTES];
    logic [31:0] regs [32];

    logic [2:0]  state, state_n;
    logic [31:0] pc, pc_n, ir, wdata;
    logic        wen, retire;

    logic [6:0]  opcode, f7;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] rs1_v, rs2_v, i_imm, s_imm, b_imm, u_imm, j_imm;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign f7     = ir[31:25];
    assign rs1_v  = regs[ir[19:15]];
    assign rs2_v  = regs[ir[24:20]];
    assign i_imm  = {{20{ir[31]}}, ir[31:20]};
    assign s_imm  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign b_imm  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign u_imm  = {ir[31:12], 12'd0};
    assign j_imm  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    logic [31:0] alu_b, alu_out, sra_v;
    logic [4:0]  shamt;
    logic        br_take;

    assign alu_b = (opcode == OP_REG) ? rs2_v : i_imm;
    assign shamt = alu_b[4:0];
    assign sra_v = $signed(rs1_v) >>> shamt;

    always_comb begin
        case (f3)
            3'd0:    alu_out = (opcode == OP_REG && f7[5]) ? rs1_v - alu_b : rs1_v + alu_b;
            3'd1:    alu_out = rs1_v << shamt;
            3'd2:    alu_out = {31'd0, $signed(rs1_v) < $signed(alu_b)};
            3'd3:    alu_out = {31'd0, rs1_v < alu_b};
            3'd4:    alu_out = rs1_v ^ alu_b;
            3'd5:    alu_out = f7[5] ? sra_v : rs1_v >> shamt;
            3'd6:    alu_out = rs1_v | alu_b;
            default: alu_out = rs1_v & alu_b;
        endcase
        case (f3)
            3'd0:    br_take = rs1_v == rs2_v;
            3'd1:    br_take = rs1_v != rs2_v;
            3'd4:    br_take = $signed(rs1_v) < $signed(rs2_v);
            3'd5:    br_take = $signed(rs1_v) >= $signed(rs2_v);
            3'd6:    br_take = rs1_v < rs2_v;
            3'd7:    br_take = rs1_v >= rs2_v;
            default: br_take = 1'b0;
        endcase
    end

    // Effective address is recomputed in MEM; rs1 and ir cannot change in between.
    logic [31:0]   ea, ld_v;
    logic [DA-1:0] a0, a1, a2, a3;

    assign ea = rs1_v + ((opcode == OP_STORE) ? s_imm : i_imm);
    assign a0 = ea[DA-1:0];
    assign a1 = a0 + DA'(1);
    assign a2 = a0 + DA'(2);
    assign a3 = a0 + DA'(3);

    always_comb begin
        case (f3)
            3'd0:    ld_v = {{24{dmem[a0][7]}}, dmem[a0]};
            3'd1:    ld_v = {{16{dmem[a1][7]}}, dmem[a1], dmem[a0]};
            3'd4:    ld_v = {24'd0, dmem[a0]};
            3'd5:    ld_v = {16'd0, dmem[a1], dmem[a0]};
            default: ld_v = {dmem[a3], dmem[a2], dmem[a1], dmem[a0]};
        endcase
    end

    // Multiply shifts {md_hi,md_lo} right with shift-add; divide shifts it left
    // as {remainder,quotient} with restoring subtraction. Operands are magnitudes.
    logic [31:0] md_hi, md_lo, md_b, md_hi_n, md_lo_n, md_out, quo, rem;
    logic [32:0] mul_sum, div_sh, div_diff;
    logic [63:0] prod;
    logic [4:0]  md_cnt;
    logic        md_neg_a, md_neg_b, a_signed, b_signed;

    assign a_signed = !(f3 == 3'd3 || f3 == 3'd5 || f3 == 3'd7);
    assign b_signed = a_signed && (f3 != 3'd2);

    always_comb begin
        mul_sum  = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : 33'd0);
        div_sh   = {md_hi, md_lo[31]};
        div_diff = div_sh - {1'b0, md_b};
        if (!f3[2]) begin
            md_hi_n = mul_sum[32:1];
            md_lo_n = {mul_sum[0], md_lo[31:1]};
        end else if (div_sh >= {1'b0, md_b}) begin
            md_hi_n = div_diff[31:0];
            md_lo_n = {md_lo[30:0], 1'b1};
        end else begin
            md_hi_n = div_sh[31:0];
            md_lo_n = {md_lo[30:0], 1'b0};
        end
        prod = (md_neg_a ^ md_neg_b) ? -{md_hi_n, md_lo_n} : {md_hi_n, md_lo_n};
        if (md_b == '0) begin
            quo = '1;
            rem = rs1_v;
        end else begin
            quo = (md_neg_a ^ md_neg_b) ? -md_lo_n : md_lo_n;
            rem = md_neg_a ? -md_hi_n : md_hi_n;
        end
        case (f3)
            3'd0:          md_out = prod[31:0];
            3'd1, 3'd2, 3'd3: md_out = prod[63:32];
            3'd4, 3'd5:    md_out = quo;
            default:       md_out = rem;
        endcase
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        wen     = 1'b0;
        wdata   = '0;
        retire  = 1'b0;
        case (state)
            FETCH: state_n = EXEC;
            EXEC: begin
                state_n = FETCH;
                pc_n    = pc + 32'd4;
                retire  = 1'b1;
                case (opcode)
                    OP_LUI:   begin wen = 1'b1; wdata = u_imm; end
                    OP_AUIPC: begin wen = 1'b1; wdata = pc + u_imm; end
                    OP_JAL:   begin wen = 1'b1; wdata = pc + 32'd4; pc_n = pc + j_imm; end
                    OP_JALR:  begin wen = 1'b1; wdata = pc + 32'd4; pc_n = (rs1_v + i_imm) & ~32'd1; end
                    OP_BR:    if (br_take) pc_n = pc + b_imm;
                    OP_LOAD, OP_STORE: begin state_n = MEM; pc_n = pc; retire = 1'b0; end
                    OP_IMM:   begin wen = 1'b1; wdata = alu_out; end
                    OP_REG: begin
                        if (f7 == 7'b0000001) begin
                            state_n = MULDIV;
                            pc_n    = pc;
                            retire  = 1'b0;
                        end else begin
                            wen   = 1'b1;
                            wdata = alu_out;
                        end
                    end
                    OP_SYS: if (ir == 32'h0000_0073) begin state_n = HALT; pc_n = pc; end
                    default: ;
                endcase
            end
            MEM: begin
                state_n = FETCH;
                pc_n    = pc + 32'd4;
                retire  = 1'b1;
                wen     = (opcode == OP_LOAD);
                wdata   = ld_v;
            end
            MULDIV: if (md_cnt == 5'd31) begin
                state_n = FETCH;
                pc_n    = pc + 32'd4;
                retire  = 1'b1;
                wen     = 1'b1;
                wdata   = md_out;
            end
            HALT: ;
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (insMemEn) imem[insMemAddr[IA-1:0]] <= insMemData;
    end

    always_ff @(posedge clock) begin
        if (!reset && !insMemEn && state == MEM && opcode == OP_STORE) begin
            dmem[a0] <= rs2_v[7:0];
            if (f3[1:0] != 2'd0) dmem[a1] <= rs2_v[15:8];
            if (f3[1]) begin
                dmem[a2] <= rs2_v[23:16];
                dmem[a3] <= rs2_v[31:24];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            result  <= '0;
            halted  <= 1'b0;
            instret <= '0;
            md_hi   <= '0;
            md_lo   <= '0;
            md_b    <= '0;
            md_cnt  <= '0;
            md_neg_a <= 1'b0;
            md_neg_b <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else if (insMemEn) begin
            state <= FETCH;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (state == FETCH) ir <= imem[pc[IA+1:2]];
            if (wen && rd != 5'd0) begin
                regs[rd] <= wdata;
                result   <= wdata;
            end
            if (retire) instret <= instret + 32'd1;
            if (state_n == HALT) halted <= 1'b1;
            if (state == EXEC) begin
                md_neg_a <= a_signed & rs1_v[31];
                md_neg_b <= b_signed & rs2_v[31];
                md_lo    <= (a_signed & rs1_v[31]) ? -rs1_v : rs1_v;
                md_b     <= (b_signed & rs2_v[31]) ? -rs2_v : rs2_v;
                md_hi    <= '0;
                md_cnt   <= '0;
            end else if (state == MULDIV) begin
                md_hi  <= md_hi_n;
                md_lo  <= md_lo_n;
                md_cnt <= md_cnt + 5'd1;
            end
        end
    end

    assign gp = regs[3];
    assign a7 = regs[17];

    logic unused_bits;
    assign unused_bits = &{1'b0, insMemAddr[WIDTH-1:IA], ea[31:DA]};

endmodule

// File: tb/tb_rv32im_multicycle_core.sv
// Directed-program bench for rv32im_multicycle_core; expected values are
// hand-computed from the RV32IM semantics of each small program.
module tb_rv32im_multicycle_core;
    logic        clock;
    logic        reset;
    logic        insMemEn;
    logic [31:0] insMemAddr, insMemData;
    logic [31:0] result, gp, a7, instret;
    logic        halted;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned c0, t0;
    logic [31:0] prog [$];

    rv32im_multicycle_core #(
        .WIDTH(32),
        .IMEM_WORDS(512),
        .DMEM_BYTES(1024)
    ) dut (
        .clock(clock),
        .reset(reset),
        .insMemEn(insMemEn),
        .insMemAddr(insMemAddr),
        .insMemData(insMemData),
        .result(result),
        .gp(gp),
        .a7(a7),
        .halted(halted),
        .instret(instret)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] rr(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] ld(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'h03};
    endfunction
    function automatic logic [31:0] st(input logic [2:0] f3, input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] ut(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h67};
    endfunction

    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [6:0]  M7    = 7'b0000001;

    task automatic emit(input logic [31:0] w);
        prog.push_back(w);
    endtask

    // Writes prog through the loader; optionally follows with a reset pulse.
    task automatic load(input bit do_reset);
        for (int i = 0; i < prog.size(); i++) begin
            @(negedge clock);
            insMemEn   = 1'b1;
            insMemAddr = 32'(i);
            insMemData = prog[i];
        end
        @(negedge clock);
        insMemEn = 1'b0;
        if (do_reset) begin
            reset = 1'b1;
            repeat (2) @(negedge clock);
            reset = 1'b0;
        end
    endtask

    task automatic wait_ret(input logic [31:0] n, input int unsigned budget);
        int unsigned k = 0;
        while (instret !== n && k < budget) begin
            @(negedge clock);
            k++;
        end
        check_eq("instret_reached", instret, n);
    endtask

    task automatic wait_halt(input int unsigned budget);
        int unsigned k = 0;
        while (halted !== 1'b1 && k < budget) begin
            @(negedge clock);
            k++;
        end
        check_eq("halted_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        reset = 1'b1; insMemEn = 1'b0; insMemAddr = '0; insMemData = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Arithmetic and ECALL
        prog.delete();
        emit(addi(5'd3, 5'd0, 12'd5));
        emit(addi(5'd17, 5'd3, 12'hFF9));
        emit(ECALL);
        load(1);
        c0 = cyc;
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_instret", instret, 32'd0);
        check_eq("rst_gp", gp, 32'd0);
        wait_halt(50);
        check_eq("arith_cycles", cyc - c0, 32'd6);
        check_eq("arith_gp", gp, 32'd5);
        check_eq("arith_a7", a7, 32'hFFFF_FFFE);
        check_eq("arith_instret", instret, 32'd3);
        check_eq("arith_result", result, 32'hFFFF_FFFE);
        repeat (4) @(negedge clock);
        check_eq("halt_instret_frozen", instret, 32'd3);

        // Byte/half loads and stores, address wrap
        prog.delete();
        emit(addi(5'd1, 5'd0, 12'h080));
        emit(ut(7'h37, 5'd2, 20'h12345));
        emit(addi(5'd2, 5'd2, 12'h678));
        emit(st(3'd2, 5'd2, 5'd1, 12'd0));
        emit(ld(3'd0, 5'd3, 5'd1, 12'd3));
        emit(ld(3'd4, 5'd17, 5'd1, 12'd3));
        emit(ld(3'd1, 5'd3, 5'd1, 12'd2));
        emit(ld(3'd5, 5'd17, 5'd1, 12'd2));
        emit(addi(5'd4, 5'd0, 12'hF80));
        emit(st(3'd0, 5'd4, 5'd1, 12'd1));
        emit(ld(3'd0, 5'd3, 5'd1, 12'd1));
        emit(ld(3'd4, 5'd17, 5'd1, 12'd1));
        emit(ld(3'd2, 5'd3, 5'd1, 12'd0));
        emit(st(3'd2, 5'd2, 5'd0, 12'hFFF));
        emit(ld(3'd2, 5'd17, 5'd0, 12'hFFF));
        emit(ld(3'd4, 5'd3, 5'd0, 12'd1));
        emit(ECALL);
        load(1);
        c0 = cyc;
        wait_ret(32'd6, 100);
        check_eq("lb_hi", gp, 32'h0000_0012);
        check_eq("lbu_hi", a7, 32'h0000_0012);
        wait_ret(32'd8, 100);
        check_eq("lh", gp, 32'h0000_1234);
        check_eq("lhu", a7, 32'h0000_1234);
        wait_ret(32'd12, 100);
        check_eq("sb_lb", gp, 32'hFFFF_FF80);
        check_eq("sb_lbu", a7, 32'h0000_0080);
        wait_ret(32'd13, 100);
        check_eq("lw_after_sb", gp, 32'h1234_8078);
        wait_ret(32'd16, 100);
        check_eq("wrap_lw", a7, 32'h1234_5678);
        check_eq("wrap_lbu", gp, 32'h0000_0034);
        wait_halt(100);
        check_eq("mem_cycles", cyc - c0, 32'd46);

        // M extension
        prog.delete();
        emit(addi(5'd1, 5'd0, 12'hFFE));
        emit(addi(5'd2, 5'd0, 12'd3));
        emit(rr(M7, 3'd1, 5'd3, 5'd1, 5'd2));
        emit(addi(5'd4, 5'd0, 12'hFFF));
        emit(addi(5'd5, 5'd0, 12'd2));
        emit(rr(M7, 3'd3, 5'd17, 5'd4, 5'd5));
        emit(addi(5'd6, 5'd0, 12'd7));
        emit(rr(M7, 3'd4, 5'd3, 5'd6, 5'd0));
        emit(rr(M7, 3'd6, 5'd17, 5'd6, 5'd0));
        emit(ut(7'h37, 5'd7, 20'h80000));
        emit(rr(M7, 3'd4, 5'd3, 5'd7, 5'd4));
        emit(rr(M7, 3'd6, 5'd17, 5'd7, 5'd4));
        emit(rr(M7, 3'd0, 5'd3, 5'd1, 5'd2));
        emit(rr(M7, 3'd5, 5'd17, 5'd6, 5'd5));
        emit(addi(5'd8, 5'd0, 12'hFF9));
        emit(rr(M7, 3'd4, 5'd3, 5'd8, 5'd5));
        emit(rr(M7, 3'd6, 5'd17, 5'd8, 5'd5));
        emit(rr(M7, 3'd2, 5'd3, 5'd2, 5'd4));
        emit(rr(M7, 3'd7, 5'd17, 5'd8, 5'd5));
        emit(ECALL);
        load(1);
        wait_ret(32'd2, 20);
        t0 = cyc;
        wait_ret(32'd3, 60);
        check_eq("mulh_cycles", cyc - t0, 32'd34);
        check_eq("mulh", gp, 32'hFFFF_FFFF);
        wait_ret(32'd6, 100);
        check_eq("mulhu", a7, 32'd1);
        wait_ret(32'd7, 20);
        t0 = cyc;
        wait_ret(32'd8, 60);
        check_eq("div_cycles", cyc - t0, 32'd34);
        check_eq("div_by_zero", gp, 32'hFFFF_FFFF);
        wait_ret(32'd9, 60);
        check_eq("rem_by_zero", a7, 32'd7);
        wait_ret(32'd11, 100);
        check_eq("div_overflow", gp, 32'h8000_0000);
        wait_ret(32'd12, 60);
        check_eq("rem_overflow", a7, 32'd0);
        wait_ret(32'd13, 60);
        check_eq("mul", gp, 32'hFFFF_FFFA);
        wait_ret(32'd14, 60);
        check_eq("divu", a7, 32'd3);
        wait_ret(32'd16, 100);
        check_eq("div_neg", gp, 32'hFFFF_FFFD);
        wait_ret(32'd17, 60);
        check_eq("rem_neg", a7, 32'hFFFF_FFFF);
        wait_ret(32'd18, 60);
        check_eq("mulhsu", gp, 32'd2);
        wait_ret(32'd19, 60);
        check_eq("remu", a7, 32'd1);
        wait_halt(20);

        // Branch loop, JALR to odd target, AUIPC
        prog.delete();
        emit(addi(5'd5, 5'd0, 12'd0));
        emit(addi(5'd6, 5'd0, 12'd10));
        emit(addi(5'd5, 5'd5, 12'd1));
        emit(br(3'd1, 5'd5, 5'd6, 13'h1FFC));
        emit(addi(5'd3, 5'd5, 12'd0));
        emit(addi(5'd1, 5'd0, 12'd33));
        emit(jalr(5'd17, 5'd1, 12'd0));
        emit(addi(5'd3, 5'd0, 12'd99));
        emit(ut(7'h17, 5'd3, 20'h00001));
        emit(ECALL);
        load(1);
        wait_ret(32'd23, 100);
        check_eq("bne_loop_x5", gp, 32'd10);
        wait_halt(50);
        check_eq("jalr_link", a7, 32'd28);
        check_eq("auipc_after_jalr", gp, 32'h0000_1020);
        check_eq("branch_instret", instret, 32'd27);

        // Reset during a divide
        prog.delete();
        emit(addi(5'd3, 5'd0, 12'd100));
        emit(addi(5'd17, 5'd0, 12'd7));
        emit(rr(M7, 3'd4, 5'd3, 5'd3, 5'd17));
        emit(ECALL);
        load(1);
        wait_ret(32'd2, 20);
        repeat (16) @(negedge clock);
        check_eq("muldiv_rd_unchanged", gp, 32'd100);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("abort_gp", gp, 32'd0);
        check_eq("abort_a7", a7, 32'd0);
        check_eq("abort_instret", instret, 32'd0);
        check_eq("abort_result", result, 32'd0);
        wait_halt(100);
        check_eq("rerun_div", gp, 32'd14);
        check_eq("rerun_instret", instret, 32'd4);

        // Loader asserted mid-instruction
        prog.delete();
        for (int i = 0; i < 8; i++) emit(addi(5'd3, 5'd3, 12'd1));
        emit(ECALL);
        load(1);
        wait_ret(32'd3, 20);
        check_eq("pre_load_gp", gp, 32'd3);
        prog.delete();
        for (int i = 0; i < 8; i++) emit(addi(5'd17, 5'd17, 12'd5));
        emit(ECALL);
        load(0);
        t0 = cyc;
        check_eq("load_instret_held", instret, 32'd3);
        check_eq("load_gp_held", gp, 32'd3);
        check_eq("load_a7_held", a7, 32'd0);
        wait_ret(32'd4, 20);
        check_eq("resume_cycles", cyc - t0, 32'd2);
        check_eq("resume_a7", a7, 32'd5);
        wait_halt(50);
        check_eq("reload_a7", a7, 32'd25);
        check_eq("reload_gp", gp, 32'd3);
        check_eq("reload_instret", instret, 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32im_multicycle_core.md
# rv32im_multicycle_core

Multicycle RV32IM core that succeeds the single-cycle datapath. It keeps the same instruction-loader port and the same gp/a7 verification taps. Instruction and data memory depths are parametrised, and the core adds byte/halfword loads and stores, the full M extension through an iterative multiply/divide unit, an ECALL halt, and a retired-instruction counter. It is the top-level compute block of the design; all memories are internal.

## Interface
- WIDTH, 32: datapath width. Only 32 is supported.
- IMEM_WORDS, 512: instruction memory depth in words (power of 2).
- DMEM_BYTES, 1024: data memory depth in bytes (power of 2).
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- insMemEn  in  1  loader enable; the core is held idle while high.
- insMemAddr  in  WIDTH  loader word index; low log2(IMEM_WORDS) bits are used.
- insMemData  in  WIDTH  loader write data.
- result  out  WIDTH  last value written to the register file.
- gp  out  WIDTH  live value of x3.
- a7  out  WIDTH  live value of x17.
- halted  out  1  sticky; set when ECALL retires.
- instret  out  WIDTH  count of retired instructions.

## Operation
- **States:** FETCH, EXEC, MEM, MULDIV, HALT.
- **Reset:**
  - pc=0, state=FETCH.
  - All 32 registers cleared.
  - result=0, halted=0, instret=0.
  - Data memory is not cleared.
- **Loader:**
  - While insMemEn=1, imem[insMemAddr] is written with insMemData every cycle.
  - State is forced to FETCH, pc holds, and there are no register or dmem writes.
  - Execution resumes on the first cycle with insMemEn=0.
- **FETCH:** ir <= imem[pc[log2(IMEM_WORDS)+1:2]] (synchronous read). Next state is EXEC.
- **EXEC:** decodes ir and computes the ALU result, branch decision and effective address.
  - OP / OP-IMM / LUI / AUIPC / JAL / JALR: write rd, update pc, retire, go to FETCH.
  - Branches: if taken, pc <= pc + sbImm; otherwise pc <= pc + 4.
  - JALR target: (rs1 + iImm) & ~1.
  - Loads and stores: go to MEM.
  - MUL-family (opcode OP, funct7=0000001): latch operands, go to MULDIV.
  - ECALL (0x00000073): go to HALT, set halted, retire.
  - FENCE and all unrecognised opcodes: no-op, pc+4, retire.
- **MEM:** byte-addressed, little-endian; addresses wrap modulo DMEM_BYTES. Misaligned accesses are performed bytewise with no trap.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW loads 4 bytes.
  - SB/SH/SW write 1/2/4 bytes from rs2.
  - Retire, pc+4, go to FETCH.
- **MULDIV:** runs exactly 32 iterations regardless of operands.
  - MUL, MULH, MULHSU, MULHU: shift-add over magnitudes, then sign correction of the 64-bit product.
  - DIV, DIVU, REM, REMU: restoring division.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - DIV of 0x80000000 by -1: quotient = 0x80000000, remainder = 0.
  - On the 32nd cycle: write rd, retire, pc+4, go to FETCH.
- **HALT:** terminal until reset. No writes; pc is frozen at the ECALL address.
- **Register file:**
  - x0 always reads 0; writes to x0 are discarded.
  - result updates on every non-x0 write.
- **instret:** increments by 1 on each retirement and wraps at 2^WIDTH.

## Timing
- Latency in cycles, from FETCH entry to next FETCH entry:
  - ALU, branch, jump, LUI, AUIPC, NOP: 2.
  - Loads and stores: 3.
  - M-extension: 34.
  - ECALL: 2 to HALT.
- Register write, pc update and instret increment all occur on the same edge as the retiring state's exit.
- A register written by one instruction is visible in the next instruction's EXEC.
- A store's bytes are visible to a load issued in the following instruction.
- Asserting reset mid-MULDIV or mid-MEM aborts the instruction: no rd write, no instret increment. The state is FETCH with pc=0 on the next cycle.
- insMemEn asserted mid-instruction also aborts it with no writes. pc keeps its value, so that instruction is refetched once insMemEn drops.

## Test plan
- **Arithmetic:** load addi x3,x0,5; addi x17,x3,-7; ecall.
  - Expect gp=5, a7=0xFFFFFFFE.
  - halted=1 after 6 cycles; instret=3.
- **Byte/half stores and loads:** x1=0x80; sw 0x12345678 to [x1]; then lb, lbu, lh and lhu at [x1+3] and [x1+2].
  - Expect 0x00000012, 0x00000012, 0x00001234, 0x00001234.
  - Store 0x80 via sb, then lb returns 0xFFFFFF80.
- **M extension:**
  - mulh(-2, 3) = 0xFFFFFFFF; mulhu(0xFFFFFFFF, 2) = 1.
  - div(7, 0) = 0xFFFFFFFF; rem(7, 0) = 7; div(0x80000000, -1) = 0x80000000.
  - Each instruction takes 34 cycles.
- **Branch and jump:**
  - bne loop counting x5 from 0 to 10 ends with x5=10.
  - jalr to an odd target clears bit 0; rd receives pc+4.
- **Reset mid-divide:** assert reset at MULDIV cycle 15.
  - rd is unchanged-then-cleared (all registers 0); pc=0; instret=0.
  - The program re-executes correctly afterwards.
- **Loader:** hold insMemEn while reloading the program.
  - No register writes occur; instret stays constant.
  - Execution starts at the current pc one cycle after insMemEn falls.
